spi_slave_modport: RTL and testbench

SPI_SLAVE_MODPORT -- requirements
Module: spi_slave_modport

---
 rtl/spi_s_pkg.sv | 18 +
 rtl/spi_s_sync.sv | 34 +++
 rtl/spi_slave_modport.sv | 120 ++++++++++++
 tb/tb_spi_slave_modport.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_s_pkg.sv
// Shared constants and types for the SPI slave.
// Holds byte width, mode encoding and reset values.
package spi_s_pkg;

  localparam int SPI_BITS = 8;
  localparam int CNT_W    = $clog2(SPI_BITS);

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam logic [SPI_BITS-1:0] RX_RST  = '0;
  localparam logic [SPI_BITS-1:0] TX_RST  = '0;
  localparam logic [SPI_BITS-1:0] SH_RST  = '0;
  localparam logic [CNT_W-1:0]    CNT_RST = '0;

endpackage

// File: rtl/spi_s_sync.sv
// 2-flop synchronizer with rise/fall pulse outputs.
// Ports: i_Clk, i_Rst_L, i_async -> o_sync, o_rise, o_fall.
module spi_s_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= i_async;
      sync <= meta;
      prev <= sync;
    end
  end

  assign o_sync = sync;
  assign o_rise = sync & ~prev;
  assign o_fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_modport.sv
// SPI slave, modes 0..3, MSB first, oversampled by i_Clk.
// Ports: i_Clk/i_Rst_L, TX byte+DV in, RX byte+DV out, SPI pins.
// Macro SPI_S_MISO_TRISTATE_EN: MISO is z while CS_n is high.
module spi_slave_modport
  import spi_s_pkg::*;
#(
  parameter int SPI_MODE = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  input  logic       i_SPI_CS_n
);

  localparam spi_mode_t MODE = spi_mode_t'(SPI_MODE[1:0]);

  logic sclk_s, sclk_r, sclk_f;
  logic mosi_s, mosi_r, mosi_f;
  logic cs_s, cs_r, cs_f;
  logic unused_edges;

  spi_s_sync #(.RST_VAL(MODE.cpol)) u_sclk (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_async (i_SPI_Clk),
    .o_sync  (sclk_s),
    .o_rise  (sclk_r),
    .o_fall  (sclk_f)
  );

  spi_s_sync #(.RST_VAL(1'b0)) u_mosi (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_async (i_SPI_MOSI),
    .o_sync  (mosi_s),
    .o_rise  (mosi_r),
    .o_fall  (mosi_f)
  );

  spi_s_sync #(.RST_VAL(1'b1)) u_cs (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_async (i_SPI_CS_n),
    .o_sync  (cs_s),
    .o_rise  (cs_r),
    .o_fall  (cs_f)
  );

  assign unused_edges = ^{sclk_s, mosi_r, mosi_f, cs_r};

  logic lead;
  logic trail;
  logic smp_edge;
  logic sh_edge;

  assign lead     = MODE.cpol ? sclk_f : sclk_r;
  assign trail    = MODE.cpol ? sclk_r : sclk_f;
  assign smp_edge = MODE.cpha ? trail : lead;
  assign sh_edge  = MODE.cpha ? lead : trail;

  logic [SPI_BITS-1:0] tx_buf;
  logic [SPI_BITS-1:0] miso_sh;
  logic [SPI_BITS-2:0] rx_sh;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SPI_BITS-1:0] rx_byte;
  logic                rx_dv;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPI_BITS - 1);

  // A shift edge with bit_cnt == 0 is a byte boundary: for CPHA=0 it
  // is the trailing edge after the 8th sample, for CPHA=1 the first
  // leading edge of the next byte. Either way the buffer is reloaded.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tx_buf  <= TX_RST;
      miso_sh <= SH_RST;
      rx_sh   <= SH_RST[SPI_BITS-2:0];
      bit_cnt <= CNT_RST;
      rx_byte <= RX_RST;
      rx_dv   <= 1'b0;
    end else begin
      rx_dv <= 1'b0;
      if (i_TX_DV) tx_buf <= i_TX_Byte;
      if (cs_s) begin
        bit_cnt <= CNT_RST;
      end else begin
        if (cs_f) begin
          miso_sh <= tx_buf;
        end else if (sh_edge) begin
          if (bit_cnt == CNT_RST) miso_sh <= tx_buf;
          else miso_sh <= {miso_sh[SPI_BITS-2:0], 1'b0};
        end
        if (smp_edge) begin
          rx_sh   <= {rx_sh[SPI_BITS-3:0], mosi_s};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            rx_byte <= {rx_sh, mosi_s};
            rx_dv   <= 1'b1;
          end
        end
      end
    end
  end

  assign o_RX_Byte = rx_byte;
  assign o_RX_DV   = rx_dv;

`ifdef SPI_S_MISO_TRISTATE_EN
  assign o_SPI_MISO = cs_s ? 1'bz : miso_sh[SPI_BITS-1];
`else
  assign o_SPI_MISO = cs_s ? 1'b1 : miso_sh[SPI_BITS-1];
`endif

endmodule

// File: tb/tb_spi_slave_modport.sv
// Scoreboard bench for spi_slave_modport, modes 0 and 3.
// Directed SPI master vectors; RX bytes checked by monitors.
module tb_spi_slave_modport;

  localparam int HP = 8;

`ifdef SPI_S_MISO_TRISTATE_EN
  localparam logic IDLE = 1'bz;
`else
  localparam logic IDLE = 1'b1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] tx0, tx3;
  logic       tv0, tv3;
  logic [7:0] rx0, rx3;
  logic       dv0, dv3;
  logic       sclk0, sclk3;
  logic       mosi0, mosi3;
  logic       miso0, miso3;
  logic       cs0, cs3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q0[$];
  logic [7:0] q3[$];

  spi_slave_modport #(.SPI_MODE(0)) u0 (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_TX_Byte  (tx0),
    .i_TX_DV    (tv0),
    .o_RX_Byte  (rx0),
    .o_RX_DV    (dv0),
    .i_SPI_Clk  (sclk0),
    .i_SPI_MOSI (mosi0),
    .o_SPI_MISO (miso0),
    .i_SPI_CS_n (cs0)
  );

  spi_slave_modport #(.SPI_MODE(3)) u3 (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_TX_Byte  (tx3),
    .i_TX_DV    (tv3),
    .o_RX_Byte  (rx3),
    .o_RX_DV    (dv3),
    .i_SPI_Clk  (sclk3),
    .i_SPI_MOSI (mosi3),
    .o_SPI_MISO (miso3),
    .i_SPI_CS_n (cs3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [7:0] act,
                              logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && dv0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx0_extra: got %h expected none", rx0);
      end else begin
        chk("rx0_byte", rx0, q0.pop_front());
      end
    end
    if (rst_n === 1'b1 && dv3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx3_extra: got %h expected none", rx3);
      end else begin
        chk("rx3_byte", rx3, q3.pop_front());
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sclk(input int inst, input logic v);
    if (inst == 0) sclk0 = v;
    else sclk3 = v;
  endtask

  task automatic set_mosi(input int inst, input logic v);
    if (inst == 0) mosi0 = v;
    else mosi3 = v;
  endtask

  task automatic set_cs(input int inst, input logic v);
    if (inst == 0) cs0 = v;
    else cs3 = v;
  endtask

  function automatic logic get_miso(input int inst);
    return (inst == 0) ? miso0 : miso3;
  endfunction

  task automatic load_tx(input int inst, input logic [7:0] b);
    if (inst == 0) begin
      tx0 = b;
      tv0 = 1'b1;
    end else begin
      tx3 = b;
      tv3 = 1'b1;
    end
    wait_n(1);
    tv0 = 1'b0;
    tv3 = 1'b0;
  endtask

  task automatic cs_low(input int inst);
    set_cs(inst, 1'b0);
    wait_n(HP);
  endtask

  task automatic cs_high(input int inst);
    wait_n(HP);
    set_cs(inst, 1'b1);
    wait_n(HP);
  endtask

  // Bits lo..hi-1 of one byte, MSB first. Instance 0 is mode 0,
  // instance 3 is mode 3.
  task automatic xfer_bits(input int inst, input logic [7:0] mo,
                           input int lo, input int hi,
                           inout logic [7:0] mi);
    logic cpl;
    cpl = (inst != 0);
    for (int i = lo; i < hi; i++) begin
      if (inst == 0) begin
        set_mosi(inst, mo[7-i]);
        wait_n(HP);
        mi[7-i] = get_miso(inst);
        set_sclk(inst, ~cpl);
        wait_n(HP);
        set_sclk(inst, cpl);
      end else begin
        set_sclk(inst, ~cpl);
        set_mosi(inst, mo[7-i]);
        wait_n(HP);
        mi[7-i] = get_miso(inst);
        set_sclk(inst, cpl);
        wait_n(HP);
      end
    end
  endtask

  task automatic xfer(input int inst, input logic [7:0] mo,
                      output logic [7:0] mi);
    logic [7:0] g;
    g = 8'h00;
    xfer_bits(inst, mo, 0, 8, g);
    mi = g;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    rst_n = 1'b0;
    tx0 = 8'h00; tx3 = 8'h00;
    tv0 = 1'b0;  tv3 = 1'b0;
    sclk0 = 1'b0; sclk3 = 1'b1;
    mosi0 = 1'b0; mosi3 = 1'b0;
    cs0 = 1'b1;  cs3 = 1'b1;
    wait_n(4);
    rst_n = 1'b1;
    wait_n(4);

    chk("rst_rx0", rx0, 8'h00);
    chk("rst_dv0", {7'b0, dv0}, 8'h00);
    chk("rst_rx3", rx3, 8'h00);
    chk("idle_miso0", {7'b0, miso0}, {7'b0, IDLE});

    // mode 0 single byte
    load_tx(0, 8'hA5);
    cs_low(0);
    q0.push_back(8'h3C);
    xfer(0, 8'h3C, got);
    chk("m0_miso", got, 8'hA5);
    cs_high(0);
    chk("idle_miso0_b", {7'b0, miso0}, {7'b0, IDLE});

    // mode 3 back-to-back, buffer retransmitted
    load_tx(3, 8'h96);
    cs_low(3);
    q3.push_back(8'h01);
    xfer(3, 8'h01, got);
    chk("m3_miso_1", got, 8'h96);
    q3.push_back(8'hFF);
    xfer(3, 8'hFF, got);
    chk("m3_miso_2", got, 8'h96);
    cs_high(3);
    chk("idle_miso3", {7'b0, miso3}, {7'b0, IDLE});

    // aborted byte: 5 bits of F0
    cs_low(0);
    got = 8'h00;
    xfer_bits(0, 8'hF0, 0, 5, got);
    cs_high(0);
    wait_n(HP);
    chk("abort_hold", rx0, 8'h3C);

    // TX load mid-byte takes effect next byte
    load_tx(0, 8'hC3);
    cs_low(0);
    got = 8'h00;
    q0.push_back(8'h11);
    xfer_bits(0, 8'h11, 0, 4, got);
    load_tx(0, 8'h5A);
    xfer_bits(0, 8'h11, 4, 8, got);
    chk("mid_cur", got, 8'hC3);
    q0.push_back(8'h22);
    xfer(0, 8'h22, got);
    chk("mid_next", got, 8'h5A);
    cs_high(0);

    // reset mid-byte
    cs_low(0);
    got = 8'h00;
    xfer_bits(0, 8'hFF, 0, 4, got);
    rst_n = 1'b0;
    wait_n(2);
    chk("mrst_rx0", rx0, 8'h00);
    chk("mrst_dv0", {7'b0, dv0}, 8'h00);
    chk("mrst_miso0", {7'b0, miso0}, {7'b0, IDLE});
    chk("mrst_rx3", rx3, 8'h00);
    cs0 = 1'b1;
    sclk0 = 1'b0;
    wait_n(2);
    rst_n = 1'b1;
    wait_n(HP);
    chk("post_rst_rx0", rx0, 8'h00);

    load_tx(0, 8'h7E);
    cs_low(0);
    q0.push_back(8'h81);
    xfer(0, 8'h81, got);
    chk("post_rst_miso", got, 8'h7E);
    cs_high(0);
    wait_n(4 * HP);

    chk("q0_left", 8'(q0.size()), 8'h00);
    chk("q3_left", 8'(q3.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
